// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer.
// Drives datapath enables from the decoded instruction class.
module multicycle_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic             beq,
  input  logic             lw,
  input  logic             sw,
  input  logic             rtype,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src_branch,
  output logic             alu_src_imm,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             retired,
  output logic [CNT_W-1:0] retired_count,
  output logic             illegal,
  output logic [2:0]       state
);

  localparam int TW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  state_t          st_q;
  state_t          st_d;
  logic            c_beq;
  logic            c_lw;
  logic            c_sw;
  logic            c_rtype;
  logic [TW-1:0]   timer_q;
  logic [CNT_W-1:0] cnt_q;
  logic            one_hot;
  logic            tmo;

  assign one_hot = $onehot({beq, lw, sw, rtype});
  // Last MEM wait cycle allowed before giving up.
  assign tmo = (MEM_TIMEOUT != 0) &&
               (timer_q == TMAX);

  assign state         = st_q;
  assign retired_count = cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= FETCH;
    else        st_q <= st_d;
  end

  // Capture decoded class once, in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_beq   <= 1'b0;
      c_lw    <= 1'b0;
      c_sw    <= 1'b0;
      c_rtype <= 1'b0;
    end else if (st_q == DECODE) begin
      c_beq   <= beq;
      c_lw    <= lw;
      c_sw    <= sw;
      c_rtype <= rtype;
    end
  end

  // MEM wait timer, cleared on the way into MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (st_q == EXEC) begin
      timer_q <= '0;
    end else if (st_q == MEM && !mem_ready) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // Retire counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (retired) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Next state and datapath enables; all 0 in reset.
  always_comb begin
    st_d          = st_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src_branch = 1'b0;
    alu_src_imm   = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    retired       = 1'b0;
    illegal       = 1'b0;
    if (rst_n) begin
      case (st_q)
        FETCH: begin
          if (instr_valid) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            st_d     = DECODE;
          end
        end
        DECODE: begin
          st_d = one_hot ? EXEC : TRAP;
        end
        EXEC: begin
          alu_src_imm = c_lw | c_sw;
          unique case (1'b1)
            c_beq: begin
              pc_write      = zero;
              pc_src_branch = zero;
              retired       = 1'b1;
              st_d          = FETCH;
            end
            c_rtype: st_d = WB;
            c_lw,
            c_sw:    st_d = MEM;
            default: st_d = TRAP;
          endcase
        end
        MEM: begin
          mem_read    = c_lw;
          mem_write   = c_sw;
          alu_src_imm = 1'b1;
          if (mem_ready) begin
            if (c_sw) begin
              retired = 1'b1;
              st_d    = FETCH;
            end else begin
              st_d = WB;
            end
          end else if (tmo) begin
            st_d = TRAP;
          end
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = c_lw;
          retired    = 1'b1;
          st_d       = FETCH;
        end
        TRAP: begin
          illegal = 1'b1;
        end
        default: st_d = TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer.
// CNT_W=4 so counter wrap is reachable quickly.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, beq, lw, sw, rtype;
  logic       zero, mem_ready;
  logic       ir_write, pc_write, pc_src_branch;
  logic       alu_src_imm, mem_read, mem_write;
  logic       mem_to_reg, reg_write, retired;
  logic [3:0] retired_count;
  logic       illegal;
  logic [2:0] state;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  multicycle_sequencer #(
    .CNT_W(4),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid),
    .beq(beq), .lw(lw), .sw(sw), .rtype(rtype),
    .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write),
    .pc_src_branch(pc_src_branch),
    .alu_src_imm(alu_src_imm),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .retired(retired), .retired_count(retired_count),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {ir_write, pc_write, pc_src_branch,
                 alu_src_imm, mem_read, mem_write,
                 mem_to_reg, reg_write, retired};

  localparam logic [3:0] C_BEQ = 4'b1000;
  localparam logic [3:0] C_LW  = 4'b0100;
  localparam logic [3:0] C_SW  = 4'b0010;
  localparam logic [3:0] C_RT  = 4'b0001;

  task automatic step(input logic iv,
                      input logic [3:0] cls,
                      input logic z,
                      input logic mr);
    @(negedge clk);
    instr_valid = iv;
    {beq, lw, sw, rtype} = cls;
    zero = z;
    mem_ready = mr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    {beq, lw, sw, rtype} = 4'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_valid = 1'b1;
    {beq, lw, sw, rtype} = C_LW;
    zero = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outs !== 9'b0) begin
      errors++;
      $display("FAIL rst_outs got %b exp 0", outs);
    end
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL rst_state got %0d/%b exp 0/0",
               state, illegal);
    end
    checks++;
    if (retired_count !== 4'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d exp 0",
               retired_count);
    end
    instr_valid = 1'b0;
    {beq, lw, sw, rtype} = 4'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [2:0] exp_st [4];
    logic       exp_rw [4];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
    exp_rw = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, C_RT, 1'b0, 1'b0);
      checks++;
      if (state !== exp_st[i] ||
          reg_write !== exp_rw[i]) begin
        errors++;
        $display("FAIL rt_seq%0d got %0d/%b exp %0d/%b",
                 i, state, reg_write,
                 exp_st[i], exp_rw[i]);
      end
    end
    checks++;
    if (retired !== 1'b1 || mem_to_reg !== 1'b0) begin
      errors++;
      $display("FAIL rt_wb got ret=%b m2r=%b exp 1/0",
               retired, mem_to_reg);
    end
    step(1'b0, 4'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 3'd0 || retired_count !== 4'd1 ||
        ir_write !== 1'b0) begin
      errors++;
      $display("FAIL rt_done got st=%0d cnt=%0d ir=%b exp 0/1/0",
               state, retired_count, ir_write);
    end
  endtask

  task automatic test_lw();
    int rd = 0;
    step(1'b1, C_LW, 1'b0, 1'b0);
    rd += int'(mem_read);
    checks++;
    if (ir_write !== 1'b1 || pc_write !== 1'b1 ||
        pc_src_branch !== 1'b0) begin
      errors++;
      $display("FAIL lw_fetch got %b%b%b exp 110",
               ir_write, pc_write, pc_src_branch);
    end
    step(1'b0, C_LW, 1'b0, 1'b0);
    rd += int'(mem_read);
    step(1'b0, C_LW, 1'b0, 1'b0);
    rd += int'(mem_read);
    checks++;
    if (state !== 3'd2 || alu_src_imm !== 1'b1) begin
      errors++;
      $display("FAIL lw_exec got st=%0d imm=%b exp 2/1",
               state, alu_src_imm);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, C_LW, 1'b0, 1'b0);
      rd += int'(mem_read);
    end
    step(1'b0, C_LW, 1'b0, 1'b1);
    rd += int'(mem_read);
    checks++;
    if (state !== 3'd3 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL lw_mem got st=%0d mw=%b exp 3/0",
               state, mem_write);
    end
    step(1'b0, 4'b0, 1'b0, 1'b0);
    rd += int'(mem_read);
    checks++;
    if (state !== 3'd4 || reg_write !== 1'b1 ||
        mem_to_reg !== 1'b1 || retired !== 1'b1) begin
      errors++;
      $display("FAIL lw_wb got st=%0d rw=%b m2r=%b ret=%b exp 4/1/1/1",
               state, reg_write, mem_to_reg, retired);
    end
    checks++;
    if (rd !== 4) begin
      errors++;
      $display("FAIL lw_rdcyc got %0d exp 4", rd);
    end
    step(1'b0, 4'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 3'd0 || retired_count !== 4'd2) begin
      errors++;
      $display("FAIL lw_done got st=%0d cnt=%0d exp 0/2",
               state, retired_count);
    end
  endtask

  task automatic test_beq();
    logic rw = 1'b0;
    step(1'b1, C_BEQ, 1'b0, 1'b0);
    rw |= reg_write;
    step(1'b0, C_BEQ, 1'b0, 1'b0);
    rw |= reg_write;
    step(1'b0, 4'b0, 1'b1, 1'b0);
    rw |= reg_write;
    checks++;
    if (state !== 3'd2 || pc_write !== 1'b1 ||
        pc_src_branch !== 1'b1 || retired !== 1'b1) begin
      errors++;
      $display("FAIL beq_taken got st=%0d pw=%b br=%b ret=%b exp 2/1/1/1",
               state, pc_write, pc_src_branch, retired);
    end
    step(1'b1, C_BEQ, 1'b1, 1'b0);
    rw |= reg_write;
    checks++;
    if (state !== 3'd0 || pc_src_branch !== 1'b0) begin
      errors++;
      $display("FAIL beq_fetch got st=%0d br=%b exp 0/0",
               state, pc_src_branch);
    end
    step(1'b0, C_BEQ, 1'b1, 1'b0);
    rw |= reg_write;
    step(1'b0, 4'b0, 1'b0, 1'b0);
    rw |= reg_write;
    checks++;
    if (pc_write !== 1'b0 || pc_src_branch !== 1'b0 ||
        retired !== 1'b1) begin
      errors++;
      $display("FAIL beq_nt got pw=%b br=%b ret=%b exp 0/0/1",
               pc_write, pc_src_branch, retired);
    end
    step(1'b0, 4'b0, 1'b0, 1'b0);
    checks++;
    if (retired_count !== 4'd4 || rw !== 1'b0) begin
      errors++;
      $display("FAIL beq_done got cnt=%0d rw=%b exp 4/0",
               retired_count, rw);
    end
  endtask

  task automatic test_trap_decode();
    step(1'b1, C_LW | C_SW, 1'b0, 1'b0);
    step(1'b0, C_LW | C_SW, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 3'd7 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL trap_enter got st=%0d ill=%b exp 7/1",
               state, illegal);
    end
    for (int i = 0; i < 3; i++)
      step(1'b1, C_RT, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd7 || illegal !== 1'b1 ||
        ir_write !== 1'b0 || retired_count !== 4'd4) begin
      errors++;
      $display("FAIL trap_sticky got st=%0d ill=%b ir=%b cnt=%0d exp 7/1/0/4",
               state, illegal, ir_write, retired_count);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0 || state !== 3'd0 ||
        retired_count !== 4'd0 || outs !== 9'b0) begin
      errors++;
      $display("FAIL trap_clear got ill=%b st=%0d cnt=%0d outs=%b exp 0/0/0/0",
               illegal, state, retired_count, outs);
    end
    do_reset();
    step(1'b1, 4'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 3'd7) begin
      errors++;
      $display("FAIL trap_none got %0d exp 7", state);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    int  n = 0;
    int  steps = 0;
    logic ret = 1'b0;
    logic mw_ok = 1'b1;
    step(1'b1, C_SW, 1'b0, 1'b0);
    step(1'b0, C_SW, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    ret |= retired;
    while (state !== 3'd7 && steps < 40) begin
      step(1'b0, 4'b0, 1'b0, 1'b0);
      steps++;
      ret |= retired;
      if (state === 3'd3) begin
        n++;
        if (mem_write !== 1'b1) mw_ok = 1'b0;
      end
    end
    checks++;
    if (state !== 3'd7 || n !== 15) begin
      errors++;
      $display("FAIL tmo_cycles got st=%0d n=%0d exp 7/15",
               state, n);
    end
    checks++;
    if (ret !== 1'b0 || retired_count !== 4'd0 ||
        mw_ok !== 1'b1) begin
      errors++;
      $display("FAIL tmo_noret got ret=%b cnt=%0d mw=%b exp 0/0/1",
               ret, retired_count, mw_ok);
    end
    do_reset();
  endtask

  task automatic test_ready_at_timeout();
    step(1'b1, C_SW, 1'b0, 1'b0);
    step(1'b0, C_SW, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++)
      step(1'b0, 4'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 3'd3 || mem_write !== 1'b1 ||
        retired !== 1'b1) begin
      errors++;
      $display("FAIL tmo_edge got st=%0d mw=%b ret=%b exp 3/1/1",
               state, mem_write, retired);
    end
    step(1'b0, 4'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 3'd0 || retired_count !== 4'd1) begin
      errors++;
      $display("FAIL tmo_edge_done got st=%0d cnt=%0d exp 0/1",
               state, retired_count);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      for (int k = 0; k < 4; k++)
        step(1'b1, C_RT, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      exp = 4'(i);
      checks++;
      if (retired_count !== exp) begin
        errors++;
        $display("FAIL wrap_%0d got %0d exp %0d",
                 i, retired_count, exp);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    step(1'b1, C_LW, 1'b0, 1'b0);
    step(1'b0, C_LW, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 3'd3 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got st=%0d rd=%b exp 3/1",
               state, mem_read);
    end
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== 9'b0 || state !== 3'd0 ||
        retired_count !== 4'd0) begin
      errors++;
      $display("FAIL mid_rst got outs=%b st=%0d cnt=%0d exp 0/0/0",
               outs, state, retired_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, C_RT, 1'b0, 1'b0);
    checks++;
    if (state !== 3'd0 || ir_write !== 1'b1) begin
      errors++;
      $display("FAIL mid_recover got st=%0d ir=%b exp 0/1",
               state, ir_write);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_trap_decode();
    test_timeout();
    test_ready_at_timeout();
    test_wrap();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
